wt_mem_req_arb: RTL and testbench
=================================

// Module: wt_mem_req_arb
// PURPOSE
//   Arbitrates the I$ and D$ memory-request handshakes onto one request stream
//   feeding the memory adapter. Buffers accepted requests in a small FIFO and
//   caps in-flight transactions per source. Routes adapter returns back to the
//   source cache using a 1-bit source tag.
// PARAMETERS
//   PayloadWidth   128  request payload bits (addr/size/tid/wdata, opaque here)
//   RtrnWidth      256  return payload bits (opaque, passed through)
//   FifoDepth      2    request FIFO entries, power of two, >=2
//   MaxOutstanding 4    max in-flight requests per source, 1..15
// PORTS
//   clk_i            in   1             clock, rising edge
//   rst_i            in   1             synchronous reset, active-high
//   ic_req_i         in   1             I$ request pending, held until acked
//   ic_ack_o         out  1             I$ request accepted (1-cycle pulse)
//   ic_data_i        in   PayloadWidth  I$ request payload
//   dc_req_i         in   1             D$ request pending, held until acked
//   dc_ack_o         out  1             D$ request accepted (1-cycle pulse)
//   dc_data_i        in   PayloadWidth  D$ request payload
//   mem_valid_o      out  1             FIFO head valid toward adapter
//   mem_ready_i      in   1             adapter accepts head
//   mem_data_o       out  PayloadWidth  head payload
//   mem_src_o        out  1             head source: 0=I$, 1=D$
//   mem_rtrn_vld_i   in   1             return beat valid from adapter
//   mem_rtrn_src_i   in   1             return source tag
//   mem_rtrn_i       in   RtrnWidth     return payload
//   ic_rtrn_vld_o    out  1             return valid to I$
//   dc_rtrn_vld_o    out  1             return valid to D$
//   rtrn_o           out  RtrnWidth     return payload, shared by both caches
//   err_o            out  1             sticky: return with zero outstanding
// BEHAVIOUR
//   Reset: FIFO empty, both counters 0, RR pointer favours I$, err_o=0.
//     All acks and valids are 0 during reset. Reset mid-operation drops
//     queued requests; a later return counts as an underflow.
//   Grant: source is eligible when its req_i=1 and its counter < MaxOutstanding.
//     A grant occurs when the FIFO is not full; at most one grant per cycle.
//     A pop in the same cycle does NOT free a slot for a push.
//   Arbitration: round-robin. With both sources eligible, the source that was
//     not granted last wins. The pointer updates only on a grant.
//   ack_o is combinational in the grant cycle; the payload and source are
//     written into the FIFO on that clock edge.
//   Latency: a request acked in cycle N is visible on mem_valid_o in N+1 at
//     the earliest (FIFO registered, no bypass).
//   Output: valid/ready handshake. Pop on mem_valid_o & mem_ready_i.
//     mem_data_o/mem_src_o stay stable while valid and not ready.
//   Counters (4 bits each): +1 on grant of that source, -1 on a return tagged
//     with that source; both in one cycle leaves the counter unchanged.
//     Saturates at MaxOutstanding by construction (grant blocked).
//   Returns: ic_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_src_i and
//     dc_rtrn_vld_o = mem_rtrn_vld_i & mem_rtrn_src_i. rtrn_o = mem_rtrn_i.
//     Pure combinational pass-through, no backpressure.
//   Underflow: a return for a source whose counter is 0 sets err_o (sticky
//     until reset) and leaves the counter at 0.
//   FIFO pointers wrap modulo FifoDepth; full/empty use an extra count bit.
// TESTING
//   1. Reset, ic_req_i=1 alone, mem_ready_i=1 -> ic_ack_o pulse cycle 1;
//      mem_valid_o=1, mem_src_o=0 cycle 2.
//   2. ic_req_i=dc_req_i=1 continuously, mem_ready_i=1 -> acks alternate
//      I$,D$,I$,D$ until both counters reach 4; then no acks until returns.
//   3. mem_ready_i=0, both reqs held -> exactly 2 acks (FifoDepth=2); then
//      head stable; ready=1 for 1 cycle -> one pop, next cycle one new ack.
//   4. I$ counter=4, return src=0 in the same cycle as an I$ grant attempt ->
//      no grant that cycle (count still 4); grant next cycle, counter stays 4.
//   5. Return src=1 with dc counter 0 -> dc_rtrn_vld_o=1, err_o=1 next cycle
//      and held; rst_i=1 for one cycle -> err_o=0.
//   6. rst_i asserted with 2 queued entries -> mem_valid_o=0 next cycle,
//      counters 0, next simultaneous request granted to I$.

Source files
------------

// File: rtl/wt_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_req_arb
// Brief    : Round-robin I$/D$ memory request arbiter with request FIFO,
//            per-source outstanding caps and tagged return routing.
// Revision : 1.0
// ============================================================================
module wt_mem_req_arb #(
    parameter int PAYLOAD_WIDTH   = 128,
    parameter int RTRN_WIDTH      = 256,
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ic_req_i,
    output logic                     ic_ack_o,
    input  logic [PAYLOAD_WIDTH-1:0] ic_data_i,
    input  logic                     dc_req_i,
    output logic                     dc_ack_o,
    input  logic [PAYLOAD_WIDTH-1:0] dc_data_i,
    output logic                     mem_valid_o,
    input  logic                     mem_ready_i,
    output logic [PAYLOAD_WIDTH-1:0] mem_data_o,
    output logic                     mem_src_o,
    input  logic                     mem_rtrn_vld_i,
    input  logic                     mem_rtrn_src_i,
    input  logic [RTRN_WIDTH-1:0]    mem_rtrn_i,
    output logic                     ic_rtrn_vld_o,
    output logic                     dc_rtrn_vld_o,
    output logic [RTRN_WIDTH-1:0]    rtrn_o,
    output logic                     err_o
);

    localparam int         PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_MAX = 4'(MAX_OUTSTANDING);

    logic [PAYLOAD_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    fifo_src_q;
    logic [PTR_W:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]               cnt_ic_q, cnt_ic_d, cnt_dc_q, cnt_dc_d;
    logic                     prio_dc_q, prio_dc_d;
    logic                     err_q, err_d;

    logic w_full, w_empty, w_ic_elig, w_dc_elig, w_grant, w_sel_dc, w_push, w_pop;
    logic w_ic_ret, w_dc_ret, w_ic_uflow, w_dc_uflow;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign w_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign w_empty = (wptr_q == rptr_q);

    assign w_ic_elig = ic_req_i && (cnt_ic_q < c_MAX);
    assign w_dc_elig = dc_req_i && (cnt_dc_q < c_MAX);
    assign w_grant   = !rst_i && !w_full && (w_ic_elig || w_dc_elig);
    assign w_sel_dc  = w_dc_elig && (!w_ic_elig || prio_dc_q);

    assign ic_ack_o  = w_grant && !w_sel_dc;
    assign dc_ack_o  = w_grant && w_sel_dc;
    assign w_push    = w_grant;

    assign mem_valid_o = !rst_i && !w_empty;
    assign mem_data_o  = fifo_data_q[rptr_q[PTR_W-1:0]];
    assign mem_src_o   = fifo_src_q[rptr_q[PTR_W-1:0]];
    assign w_pop       = mem_valid_o && mem_ready_i;

    assign ic_rtrn_vld_o = !rst_i && mem_rtrn_vld_i && !mem_rtrn_src_i;
    assign dc_rtrn_vld_o = !rst_i && mem_rtrn_vld_i && mem_rtrn_src_i;
    assign rtrn_o        = mem_rtrn_i;

    assign w_ic_ret   = ic_rtrn_vld_o;
    assign w_dc_ret   = dc_rtrn_vld_o;
    assign w_ic_uflow = w_ic_ret && (cnt_ic_q == 4'd0);
    assign w_dc_uflow = w_dc_ret && (cnt_dc_q == 4'd0);
    assign err_o      = err_q;

    // An underflowing return is ignored by the counter so it never wraps.
    always_comb begin
        cnt_ic_d  = cnt_ic_q;
        cnt_dc_d  = cnt_dc_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        prio_dc_d = prio_dc_q;
        err_d     = err_q || w_ic_uflow || w_dc_uflow;

        case ({ic_ack_o, w_ic_ret && !w_ic_uflow})
            2'b10:   cnt_ic_d = cnt_ic_q + 4'd1;
            2'b01:   cnt_ic_d = cnt_ic_q - 4'd1;
            default: cnt_ic_d = cnt_ic_q;
        endcase
        case ({dc_ack_o, w_dc_ret && !w_dc_uflow})
            2'b10:   cnt_dc_d = cnt_dc_q + 4'd1;
            2'b01:   cnt_dc_d = cnt_dc_q - 4'd1;
            default: cnt_dc_d = cnt_dc_q;
        endcase

        if (w_push) begin
            wptr_d    = wptr_q + 1'b1;
            prio_dc_d = !w_sel_dc;
        end
        if (w_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_ic_q  <= 4'd0;
            cnt_dc_q  <= 4'd0;
            prio_dc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_ic_q  <= cnt_ic_d;
            cnt_dc_q  <= cnt_dc_d;
            prio_dc_q <= prio_dc_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_data_q[wptr_q[PTR_W-1:0]] <= w_sel_dc ? dc_data_i : ic_data_i;
            fifo_src_q[wptr_q[PTR_W-1:0]]  <= w_sel_dc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wt_mem_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_mem_req_arb
// Brief    : Cycle-level reference model and scoreboard for wt_mem_req_arb.
// Revision : 1.0
// ============================================================================
module tb_wt_mem_req_arb;

    localparam int PW  = 128;
    localparam int RW  = 256;
    localparam int DEP = 2;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst, ic_req, dc_req, rdy, rv, rsrc;
    logic [PW-1:0] ic_data, dc_data;
    logic [RW-1:0] rtrn_data;
    logic          ic_ack, dc_ack, mem_valid, mem_src, ic_rv, dc_rv, err;
    logic [PW-1:0] mem_data;
    logic [RW-1:0] rtrn_out;

    typedef struct {
        logic          src;
        logic [PW-1:0] data;
    } ent_t;

    ent_t sbq[$];
    int   m_cic, m_cdc, n_chk, n_err;
    bit   m_prio_dc, m_err;

    wt_mem_req_arb #(
        .PAYLOAD_WIDTH(PW), .RTRN_WIDTH(RW), .FIFO_DEPTH(DEP), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req), .ic_ack_o(ic_ack), .ic_data_i(ic_data),
        .dc_req_i(dc_req), .dc_ack_o(dc_ack), .dc_data_i(dc_data),
        .mem_valid_o(mem_valid), .mem_ready_i(rdy), .mem_data_o(mem_data), .mem_src_o(mem_src),
        .mem_rtrn_vld_i(rv), .mem_rtrn_src_i(rsrc), .mem_rtrn_i(rtrn_data),
        .ic_rtrn_vld_o(ic_rv), .dc_rtrn_vld_o(dc_rv), .rtrn_o(rtrn_out), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: compare outputs at negedge, advance model at posedge.
    task automatic step();
        bit   e_icel, e_dcel, e_gnt, e_seldc, e_val, inc, dec;
        ent_t e;
        @(negedge clk);
        e_icel  = ic_req && (m_cic < MAX);
        e_dcel  = dc_req && (m_cdc < MAX);
        e_gnt   = !rst && (sbq.size() < DEP) && (e_icel || e_dcel);
        e_seldc = e_dcel && (!e_icel || m_prio_dc);
        e_val   = !rst && (sbq.size() > 0);
        chk("ic_ack", RW'(ic_ack), RW'(e_gnt && !e_seldc));
        chk("dc_ack", RW'(dc_ack), RW'(e_gnt && e_seldc));
        chk("mem_valid", RW'(mem_valid), RW'(e_val));
        if (e_val) begin
            chk("mem_data", RW'(mem_data), RW'(sbq[0].data));
            chk("mem_src", RW'(mem_src), RW'(sbq[0].src));
        end
        chk("ic_rtrn_vld", RW'(ic_rv), RW'(!rst && rv && !rsrc));
        chk("dc_rtrn_vld", RW'(dc_rv), RW'(!rst && rv && rsrc));
        if (rv) chk("rtrn_data", rtrn_out, rtrn_data);
        chk("err", RW'(err), RW'(m_err));
        @(posedge clk);
        if (rst) begin
            sbq.delete();
            m_cic = 0; m_cdc = 0; m_prio_dc = 1'b0; m_err = 1'b0;
        end else begin
            if (e_val && rdy) void'(sbq.pop_front());
            if (e_gnt) begin
                e.src  = e_seldc;
                e.data = e_seldc ? dc_data : ic_data;
                sbq.push_back(e);
                m_prio_dc = !e_seldc;
            end
            inc = e_gnt && !e_seldc;
            dec = rv && !rsrc;
            if (dec && m_cic == 0) m_err = 1'b1;
            m_cic = m_cic + int'(inc) - int'(dec && m_cic != 0);
            inc = e_gnt && e_seldc;
            dec = rv && rsrc;
            if (dec && m_cdc == 0) m_err = 1'b1;
            m_cdc = m_cdc + int'(inc) - int'(dec && m_cdc != 0);
        end
        #1;
        ic_data   = {$urandom, $urandom, $urandom, $urandom};
        dc_data   = {$urandom, $urandom, $urandom, $urandom};
        rtrn_data = {8{$urandom}};
    endtask

    task automatic idle_inputs();
        ic_req = 1'b0; dc_req = 1'b0; rv = 1'b0; rsrc = 1'b0;
    endtask

    // Empty the FIFO and return every outstanding request.
    task automatic drain();
        idle_inputs();
        rdy = 1'b1;
        for (int i = 0; i < 40 && (sbq.size() > 0 || m_cic > 0 || m_cdc > 0); i++) begin
            rv   = (m_cic > 0) || (m_cdc > 0);
            rsrc = (m_cic == 0);
            step();
        end
        rv = 1'b0;
        chk("drain_done", RW'(sbq.size() + m_cic + m_cdc), RW'(0));
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        m_cic = 0; m_cdc = 0; m_prio_dc = 1'b0; m_err = 1'b0;
        idle_inputs();
        rst = 1'b1; rdy = 1'b0;
        ic_data = '0; dc_data = '0; rtrn_data = '0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // Single I$ request: ack now, head visible next cycle.
        ic_req = 1'b1; rdy = 1'b1;
        step();
        ic_req = 1'b0;
        step(); step();
        drain();

        // Both requesting with ready: alternate until both caps reached.
        ic_req = 1'b1; dc_req = 1'b1; rdy = 1'b1;
        repeat (12) step();
        drain();

        // Back-pressure: FIFO fills, head holds, one pop frees one slot.
        ic_req = 1'b1; dc_req = 1'b1; rdy = 1'b0;
        repeat (4) step();
        rdy = 1'b1; step();
        rdy = 1'b0; repeat (3) step();
        drain();

        // I$ at cap: a return in the attempt cycle does not enable a grant.
        ic_req = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 20 && m_cic < MAX; i++) step();
        rv = 1'b1; rsrc = 1'b0; step();
        rv = 1'b0; step();
        ic_req = 1'b0; step();
        drain();

        // Underflow return sets sticky error, cleared only by reset.
        rv = 1'b1; rsrc = 1'b1; step();
        rv = 1'b0; repeat (3) step();
        rst = 1'b1; step();
        rst = 1'b0; step();

        // Reset with queued entries, then priority back to I$.
        ic_req = 1'b1; dc_req = 1'b1; rdy = 1'b0;
        repeat (3) step();
        idle_inputs(); rst = 1'b1; step();
        rst = 1'b0; ic_req = 1'b1; dc_req = 1'b1; step();
        step();
        drain();

        // Random traffic with well-formed returns.
        for (int i = 0; i < 400; i++) begin
            ic_req = 1'($urandom_range(0, 1));
            dc_req = 1'($urandom_range(0, 1));
            rdy    = ($urandom_range(0, 3) != 0);
            rsrc   = 1'($urandom_range(0, 1));
            rv     = ($urandom_range(0, 2) == 0) && ((rsrc ? m_cdc : m_cic) > 0);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
